// File: rtl/prg_loader.sv
// rtl/prg_loader.sv - PRG file loader: ioctl byte stream to PET RAM DMA writes with pointer patching
module prg_loader #(
  parameter logic [7:0]  PRG_INDEX = 8'h41,
  parameter logic [15:0] RAM_TOP   = 16'h8000,
  parameter logic [15:0] PTR_BASE  = 16'h002A,
  parameter int          PTR_COUNT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        dma_ready,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_clipped,
  output logic [15:0] end_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_PATCH, S_DONE
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(2 * PTR_COUNT - 1);

  state_t      r_state, w_next;
  logic        r_sel_d;
  logic [15:0] r_addr;
  logic [3:0]  r_patch_idx;
  logic        r_ioctl_wait, r_dma_we, r_load_busy, r_load_done, r_load_clipped;
  logic [15:0] r_dma_addr, r_end_addr;
  logic [7:0]  r_dma_din;

  logic w_sel, w_sel_rise, w_strobe, w_accept;
  logic w_hdr_lo_cap, w_hdr_hi_cap, w_store, w_clip, w_patch_issue, w_abort;

  assign w_sel      = ioctl_download && (ioctl_index == PRG_INDEX);
  assign w_sel_rise = w_sel && !r_sel_d;
  assign w_strobe   = ioctl_wr && w_sel;
  // The buffer entry (data or patch write) leaves on this cycle's edge.
  assign w_accept   = r_dma_we && dma_ready;

  assign ioctl_wait   = r_ioctl_wait;
  assign dma_addr     = r_dma_addr;
  assign dma_din      = r_dma_din;
  assign dma_we       = r_dma_we;
  assign load_busy    = r_load_busy;
  assign load_done    = r_load_done;
  assign load_clipped = r_load_clipped;
  assign end_addr     = r_end_addr;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and per-cycle action decode.
  always_comb begin
    w_next        = r_state;
    w_hdr_lo_cap  = 1'b0;
    w_hdr_hi_cap  = 1'b0;
    w_store       = 1'b0;
    w_clip        = 1'b0;
    w_patch_issue = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      S_IDLE: if (w_sel_rise) w_next = S_HDR_LO;
      S_HDR_LO: begin
        if (!w_sel) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else if (w_strobe && ioctl_addr == 25'd0) begin
          w_hdr_lo_cap = 1'b1;
          w_next       = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (!w_sel) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else if (w_strobe && ioctl_addr == 25'd1) begin
          w_hdr_hi_cap = 1'b1;
          w_next       = S_DATA;
        end
      end
      S_DATA: begin
        if (w_strobe && !r_dma_we) begin
          if (r_addr < RAM_TOP) w_store = 1'b1;
          else                  w_clip  = 1'b1;
        end else if (!w_sel && !r_dma_we) begin
          w_next = S_PATCH;
        end
      end
      S_PATCH: begin
        if (!r_dma_we) w_patch_issue = 1'b1;
        else if (w_accept && r_patch_idx == LAST_IDX) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: header capture, one-entry write buffer, patch writes and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_d        <= 1'b0;
      r_addr         <= 16'h0000;
      r_patch_idx    <= 4'd0;
      r_ioctl_wait   <= 1'b0;
      r_dma_we       <= 1'b0;
      r_dma_addr     <= 16'h0000;
      r_dma_din      <= 8'h00;
      r_load_busy    <= 1'b0;
      r_load_done    <= 1'b0;
      r_load_clipped <= 1'b0;
      r_end_addr     <= 16'h0000;
    end else begin
      r_sel_d     <= w_sel;
      r_load_done <= 1'b0;
      if (r_state == S_IDLE && w_sel_rise) begin
        r_load_busy    <= 1'b1;
        r_load_clipped <= 1'b0;
      end
      if (w_abort) r_load_busy <= 1'b0;
      if (w_hdr_lo_cap) r_addr[7:0]  <= ioctl_dout;
      if (w_hdr_hi_cap) r_addr[15:8] <= ioctl_dout;
      if (w_accept) begin
        r_dma_we     <= 1'b0;
        r_ioctl_wait <= 1'b0;
        if (r_state == S_PATCH) r_patch_idx <= r_patch_idx + 4'd1;
      end
      if (w_store) begin
        r_dma_addr   <= r_addr;
        r_dma_din    <= ioctl_dout;
        r_dma_we     <= 1'b1;
        r_ioctl_wait <= 1'b1;
        r_addr       <= r_addr + 16'd1;
      end
      if (w_clip) r_load_clipped <= 1'b1;
      if (r_state == S_DATA && w_next == S_PATCH) r_patch_idx <= 4'd0;
      if (w_patch_issue) begin
        r_dma_addr <= PTR_BASE + {12'd0, r_patch_idx};
        r_dma_din  <= r_patch_idx[0] ? r_addr[15:8] : r_addr[7:0];
        r_dma_we   <= 1'b1;
      end
      if (r_state == S_PATCH && w_next == S_DONE) begin
        r_load_done <= 1'b1;
        r_load_busy <= 1'b0;
        r_end_addr  <= r_addr;
      end
    end
  end

endmodule

// File: tb/tb_prg_loader.sv
// tb/tb_prg_loader.sv - table-driven bench for prg_loader
module tb_prg_loader;

  logic        clk;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        dma_ready;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din;
  logic        dma_we;
  logic        load_busy;
  logic        load_done;
  logic        load_clipped;
  logic [15:0] end_addr;

  prg_loader dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .dma_ready(dma_ready),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
    .load_busy(load_busy), .load_done(load_done),
    .load_clipped(load_clipped), .end_addr(end_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        idx;
    int                len;
    logic [0:11][7:0]  b;
    int                stall;
    int                exp_n;
    logic [15:0]       exp_end;
    logic              exp_clip;
    int                exp_done;
  } vec_t;

  vec_t v [7];

  int checks = 0;
  int errors = 0;

  logic [23:0] got [$];
  int          wait_hi;
  int          done_cnt;
  logic        stall_prev;
  logic [15:0] prev_addr;
  logic [7:0]  prev_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Record accepted writes mid-cycle and verify the buffer holds still while stalled.
  always @(negedge clk) begin
    if (reset_n) begin
      if (stall_prev && dma_we) begin
        check("stall_addr_stable", {16'h0, dma_addr}, {16'h0, prev_addr});
        check("stall_din_stable", {24'h0, dma_din}, {24'h0, prev_din});
      end
      if (dma_we && dma_ready) got.push_back({dma_addr, dma_din});
      stall_prev = dma_we && !dma_ready;
      prev_addr  = dma_addr;
      prev_din   = dma_din;
      if (ioctl_wait) wait_hi++;
      if (load_done) done_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int i, input logic [7:0] d, input int stall);
    int n;
    step();
    ioctl_addr = 25'(i);
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr = 1'b0;
    if (stall > 0) begin
      dma_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
        check("stall_wait_high", {31'h0, ioctl_wait}, 32'h1);
        check("stall_we_high", {31'h0, dma_we}, 32'h1);
        step();
      end
      dma_ready = 1'b1;
    end
    n = 0;
    while (ioctl_wait && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("wait_timeout", 32'h1, 32'h0);
  endtask

  task automatic run_vec(input int k);
    logic [23:0] exp_q [$];
    logic [15:0] a;
    string       tag;
    tag = $sformatf("v%0d", k);
    exp_q.delete();
    if (v[k].idx == 8'h41 && v[k].len >= 2) begin
      a = {v[k].b[1], v[k].b[0]};
      for (int i = 2; i < v[k].len; i++) begin
        if (a < 16'h8000) begin
          exp_q.push_back({a, v[k].b[i]});
          a = a + 16'd1;
        end
      end
      for (int p = 0; p < 6; p++)
        exp_q.push_back({16'h002A + 16'(p), (p % 2 == 1) ? a[15:8] : a[7:0]});
    end
    got.delete();
    wait_hi  = 0;
    done_cnt = 0;
    ioctl_index = v[k].idx;
    step();
    ioctl_download = 1'b1;
    step();
    for (int i = 0; i < v[k].len; i++)
      send_byte(i, v[k].b[i], (i >= 2) ? v[k].stall : 0);
    step();
    ioctl_download = 1'b0;
    repeat (40) step();
    check({tag, "_nwrites"}, 32'(got.size()), 32'(v[k].exp_n));
    check({tag, "_model_n"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) check($sformatf("%s_wr%0d", tag, i), {8'h0, got[i]}, {8'h0, exp_q[i]});
    check({tag, "_done"}, 32'(done_cnt), 32'(v[k].exp_done));
    check({tag, "_end_addr"}, {16'h0, end_addr}, {16'h0, v[k].exp_end});
    check({tag, "_clipped"}, {31'h0, load_clipped}, {31'h0, v[k].exp_clip});
    check({tag, "_busy_end"}, {31'h0, load_busy}, 32'h0);
    if (v[k].idx != 8'h41) check({tag, "_wait_never"}, 32'(wait_hi), 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wait"}, {31'h0, ioctl_wait}, 32'h0);
    check({tag, "_we"}, {31'h0, dma_we}, 32'h0);
    check({tag, "_busy"}, {31'h0, load_busy}, 32'h0);
    check({tag, "_done"}, {31'h0, load_done}, 32'h0);
    check({tag, "_clip"}, {31'h0, load_clipped}, 32'h0);
    check({tag, "_addr"}, {16'h0, dma_addr}, 32'h0);
    check({tag, "_din"}, {24'h0, dma_din}, 32'h0);
    check({tag, "_end"}, {16'h0, end_addr}, 32'h0);
  endtask

  initial begin
    int n;
    v[0] = '{8'h41, 5,  {8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC, 56'h0}, 0, 9, 16'h0404, 1'b0, 1};
    v[1] = '{8'h41, 5,  {8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC, 56'h0}, 5, 9, 16'h0404, 1'b0, 1};
    v[2] = '{8'h41, 6,  {8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33, 8'h44, 48'h0}, 0, 8, 16'h8000, 1'b1, 1};
    v[3] = '{8'h01, 10, {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 16'h0},
             0, 0, 16'h8000, 1'b1, 0};
    v[4] = '{8'h41, 1,  {8'h01, 88'h0}, 0, 0, 16'h8000, 1'b0, 0};
    v[5] = '{8'h41, 4,  {8'hFF, 8'hFF, 8'h55, 8'h66, 64'h0}, 0, 6, 16'hFFFF, 1'b1, 1};
    v[6] = '{8'h41, 2,  {8'h00, 8'h10, 80'h0}, 0, 6, 16'h1000, 1'b0, 1};

    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'h0;
    ioctl_dout     = 8'h00;
    dma_ready      = 1'b1;
    stall_prev     = 1'b0;
    wait_hi        = 0;
    done_cnt       = 0;
    repeat (3) step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();

    for (int k = 0; k < 7; k++) run_vec(k);

    // Reset while the patch write to 002C is on the bus.
    ioctl_index = 8'h41;
    step();
    ioctl_download = 1'b1;
    step();
    send_byte(0, 8'h01, 0);
    send_byte(1, 8'h04, 0);
    send_byte(2, 8'hAA, 0);
    step();
    ioctl_download = 1'b0;
    n = 0;
    while (!(dma_we && dma_addr == 16'h002C) && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) check("reset_patch_timeout", 32'h1, 32'h0);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    got.delete();
    repeat (3) step();
    reset_n = 1'b1;
    repeat (30) step();
    check("post_reset_writes", 32'(got.size()), 32'h0);
    check("post_reset_busy", {31'h0, load_busy}, 32'h0);
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prg_loader.md
Name: prg_loader

Overview:
- Consumes the HPS ioctl byte stream for PRG files and turns it into single-byte DMA writes into PET main RAM through the pet2001hw DMA port.
- Strips the 2-byte load-address header and clips writes at the RAM ceiling.
- Throttles the HPS with ioctl_wait.
- After the download ends, patches the BASIC end-of-program pointers so RUN works without a manual relink.

Parameters:
- PRG_INDEX, 8'h41: ioctl_index value that selects this loader.
- RAM_TOP, 16'h8000: first address not writable; data bytes at or above it are discarded.
- PTR_BASE, 16'h002A: zero-page address of VARTAB low byte.
- PTR_COUNT, 3: number of consecutive 16-bit pointers patched (VARTAB, ARYTAB, STREND).

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- ioctl_download, in, 1: HPS download active.
- ioctl_index, in, 8: file type index.
- ioctl_wr, in, 1: one-cycle strobe, byte valid.
- ioctl_addr, in, 25: byte offset within the file.
- ioctl_dout, in, 8: file byte.
- ioctl_wait, out, 1: stall the HPS; high while a byte is pending.
- dma_ready, in, 1: the PET side can accept a write this cycle (CPU idle phase).
- dma_addr, out, 16: RAM write address.
- dma_din, out, 8: RAM write data.
- dma_we, out, 1: write request; the transfer occurs on a cycle with dma_we && dma_ready.
- load_busy, out, 1: high from header start until pointer patching completes.
- load_done, out, 1: one-cycle pulse when patching completes.
- load_clipped, out, 1: sticky; set if any byte was discarded at RAM_TOP. Cleared at the next download start.
- end_addr, out, 16: first address after the last stored byte.

Behaviour:
- Reset (async, reset_n=0): state=IDLE. ioctl_wait, dma_we, load_busy, load_done and load_clipped are 0. dma_addr=0, dma_din=0, end_addr=0.
- "sel" = ioctl_download && ioctl_index==PRG_INDEX. Only ioctl_wr strobes with sel high are consumed; all other strobes are ignored.
- States:
  - IDLE: on a sel rising edge go to HDR_LO, set load_busy, clear load_clipped.
  - HDR_LO: a strobe with ioctl_addr==0 captures addr[7:0]; go to HDR_HI.
  - HDR_HI: a strobe with ioctl_addr==1 captures addr[15:8]; go to DATA.
  - DATA: each strobe with addr<RAM_TOP loads the one-entry buffer with dma_addr=addr and dma_din=ioctl_dout, then sets dma_we=1 and ioctl_wait=1 in the next cycle. addr increments when the byte is captured.
  - DATA, addr>=RAM_TOP: the byte is dropped, load_clipped is set, addr is not incremented, and ioctl_wait stays 0.
  - DATA, falling edge of sel: if a buffer write is still pending, finish it first, then go to PATCH.
  - PATCH: issue 2*PTR_COUNT DMA writes in order. Write k goes to PTR_BASE+k, with data addr[7:0] for even k and addr[15:8] for odd k. Each write uses the same dma_we/dma_ready handshake. After the last accepted write go to DONE.
  - DONE: pulse load_done for 1 cycle, latch end_addr=addr, clear load_busy, return to IDLE.
- Handshake:
  - dma_we stays high with stable dma_addr/dma_din until the cycle in which dma_ready=1.
  - dma_we drops the cycle after acceptance.
  - ioctl_wait drops in the same cycle as that dma_we drop.
  - Minimum latency from strobe to write is 2 cycles.
  - A strobe arriving while the buffer is full is a protocol violation and is not required to be handled, because ioctl_wait prevents it.
- Downloads shorter than 2 bytes (sel falls in HDR_LO or HDR_HI): go straight to IDLE. No patch writes, no load_done.
- Address arithmetic is 16-bit. addr wraps modulo 2^16, but writes already stop at RAM_TOP, so a header of FFFF stores nothing and sets clipped on the first data byte.
- A new sel rising edge while in PATCH or DONE is ignored until IDLE is reached.
- reset_n asserted mid-transfer aborts immediately. No partial pointer patching occurs after release.

Test Plan:
- PRG header 01 04, data AA BB CC, dma_ready=1 → DMA writes 0401=AA, 0402=BB, 0403=CC. Then patch writes 002A=04, 002B=04, 002C=04, 002D=04, 002E=04, 002F=04. Then load_done pulse, end_addr=0404.
- Same file with dma_ready low for 5 cycles per byte → ioctl_wait high throughout each stall. dma_addr/dma_din stable while stalled. Exactly 9 accepted writes in total.
- Header FE 7F, 4 data bytes → writes only to 7FFE and 7FFF. load_clipped=1, end_addr=8000, patch data 00/80.
- Download of 1 byte, then sel drops → no DMA writes, load_done never pulses, state back to IDLE.
- ioctl_index=01 stream of 10 bytes → zero DMA writes and ioctl_wait stays 0.
- Pull reset_n low during the PATCH write to 002C → all outputs 0 immediately. No further writes after release, and the next PRG load behaves normally.
